pmod_bus_bridge: RTL and testbench

//  Parametrised FPGA-side bridge between the PMOD bus pins and the hash core (top).

---
 rtl/pmod_bus_bridge.sv | 229 ++++++++++++++++++++++
 tb/tb_pmod_bus_bridge.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_bus_bridge.sv
// PMOD bus <-> hash core bridge: input synchronisers, gated output pipeline, PLL-lock reset
// sequencer, enable debouncer, sticky error and status LEDs. Optional heartbeat: BRIDGE_HEARTBEAT_EN.
module pmod_bus_bridge #(
  parameter int DATA_W          = 8,
  parameter int CTRL_IN_W       = 3,
  parameter int CTRL_OUT_W      = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int OUT_STAGES      = 2,
  parameter int LOCK_STABLE     = 16,
  parameter int RST_HOLD        = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HB_DIV          = 22
) (
  input  logic                  clk,
  input  logic                  rst_async,
  input  logic                  pll_lock_i,
  input  logic                  ena_switch_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [CTRL_IN_W-1:0]  data_ctrl_i,
  input  logic [DATA_W-1:0]     hash_i,
  input  logic [CTRL_OUT_W-1:0] hash_ctrl_i,
  input  logic                  err_i,
  output logic [DATA_W-1:0]     core_data_o,
  output logic [CTRL_IN_W-1:0]  core_ctrl_o,
  output logic                  core_rst_n_o,
  output logic                  core_ena_o,
  output logic [DATA_W-1:0]     hash_o,
  output logic [CTRL_OUT_W-1:0] hash_ctrl_o,
  output logic [3:0]            status_o
);

  localparam int MAX_LR  = (LOCK_STABLE > RST_HOLD) ? LOCK_STABLE : RST_HOLD;
  localparam int CNT_MAX = (MAX_LR > DEBOUNCE_CYCLES) ? MAX_LR : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'b001,
    HOLD      = 3'b010,
    RUN       = 3'b100
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] seq_cnt, seq_cnt_nxt;
  logic             hold_entry;
  logic             run;

  logic [1:0]       lock_sync_p;
  logic [1:0]       ena_sync_p;
  logic             lock_s;
  logic             ena_s;

  logic [DATA_W-1:0]     data_p [SYNC_STAGES];
  logic [CTRL_IN_W-1:0]  ctrl_p [SYNC_STAGES];
  logic [DATA_W-1:0]     hash_p [OUT_STAGES];
  logic [CTRL_OUT_W-1:0] hctrl_p [OUT_STAGES];

  logic [CNT_W-1:0] deb_cnt;
  logic             core_ena_q;
  logic             err_sticky;
  logic             hb_bit;
  logic [3:0]       status_q;

  // Stage: two-flop synchronisers for the slow asynchronous controls
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      lock_sync_p <= '0;
      ena_sync_p  <= '0;
    end else begin
      lock_sync_p <= {lock_sync_p[0], pll_lock_i};
      ena_sync_p  <= {ena_sync_p[0], ena_switch_i};
    end
  end

  assign lock_s = lock_sync_p[1];
  assign ena_s  = ena_sync_p[1];

  // Stage: inbound data/ctrl synchroniser chain, SYNC_STAGES deep
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_p[i] <= '0;
        ctrl_p[i] <= '0;
      end
    end else begin
      data_p[0] <= data_i;
      ctrl_p[0] <= data_ctrl_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_p[i] <= data_p[i-1];
        ctrl_p[i] <= ctrl_p[i-1];
      end
    end
  end

  assign core_data_o = run ? data_p[SYNC_STAGES-1] : '0;
  assign core_ctrl_o = run ? ctrl_p[SYNC_STAGES-1] : '0;

  // Stage: outbound hash pipeline, gated at entry so zeros drain out after leaving RUN
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      for (int i = 0; i < OUT_STAGES; i++) begin
        hash_p[i]  <= '0;
        hctrl_p[i] <= '0;
      end
    end else begin
      hash_p[0]  <= run ? hash_i : '0;
      hctrl_p[0] <= run ? hash_ctrl_i : '0;
      for (int i = 1; i < OUT_STAGES; i++) begin
        hash_p[i]  <= hash_p[i-1];
        hctrl_p[i] <= hctrl_p[i-1];
      end
    end
  end

  assign hash_o      = hash_p[OUT_STAGES-1];
  assign hash_ctrl_o = hctrl_p[OUT_STAGES-1];

  // Stage: core reset sequencer
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state   <= WAIT_LOCK;
      seq_cnt <= '0;
    end else begin
      state   <= state_nxt;
      seq_cnt <= seq_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    seq_cnt_nxt = seq_cnt;
    hold_entry  = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        if (!lock_s) begin
          seq_cnt_nxt = '0;
        end else if (seq_cnt == CNT_W'(LOCK_STABLE - 1)) begin
          state_nxt   = HOLD;
          seq_cnt_nxt = '0;
          hold_entry  = 1'b1;
        end else begin
          seq_cnt_nxt = seq_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        // Losing lock outranks finishing the hold
        if (!lock_s) begin
          state_nxt   = WAIT_LOCK;
          seq_cnt_nxt = '0;
        end else if (seq_cnt == CNT_W'(RST_HOLD - 1)) begin
          state_nxt   = RUN;
          seq_cnt_nxt = '0;
        end else begin
          seq_cnt_nxt = seq_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt   = WAIT_LOCK;
          seq_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = WAIT_LOCK;
        seq_cnt_nxt = '0;
      end
    endcase
  end

  assign run          = state[2];
  assign core_rst_n_o = state[2];

  // Stage: enable debouncer; output moves only after a full quiet window
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      deb_cnt    <= '0;
      core_ena_q <= 1'b0;
    end else if (ena_s == core_ena_q) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      core_ena_q <= ena_s;
      deb_cnt    <= '0;
    end else begin
      deb_cnt <= deb_cnt + CNT_W'(1);
    end
  end

  assign core_ena_o = core_ena_q;

  // Stage: sticky error, set has priority over the clear on HOLD entry
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      err_sticky <= 1'b0;
    end else if (run && err_i) begin
      err_sticky <= 1'b1;
    end else if (hold_entry) begin
      err_sticky <= 1'b0;
    end
  end

`ifdef BRIDGE_HEARTBEAT_EN
  logic [HB_DIV:0] hb_cnt;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      hb_cnt <= '0;
    end else if (run) begin
      hb_cnt <= hb_cnt + (HB_DIV + 1)'(1);
    end else begin
      hb_cnt <= '0;
    end
  end

  assign hb_bit = hb_cnt[HB_DIV];
`else
  assign hb_bit = 1'b0 & (HB_DIV == 0);
`endif

  // Stage: registered status LEDs
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      status_q <= 4'b0001;
    end else begin
      status_q <= {hb_bit, err_sticky, lock_s, ~run};
    end
  end

  assign status_o = status_q;

endmodule

// File: tb/tb_pmod_bus_bridge.sv
// Randomised bench for pmod_bus_bridge against a streak/history based reference model.
module tb_pmod_bus_bridge;

  localparam int DATA_W          = 8;
  localparam int CTRL_IN_W       = 3;
  localparam int CTRL_OUT_W      = 2;
  localparam int SYNC_STAGES     = 2;
  localparam int OUT_STAGES      = 2;
  localparam int LOCK_STABLE     = 16;
  localparam int RST_HOLD        = 8;
  localparam int DEBOUNCE_CYCLES = 1000;
  localparam int HB_DIV          = 3;
  localparam int MAXC            = 16384;
  localparam int RUN_AFTER       = LOCK_STABLE + RST_HOLD;

  logic                  clk = 1'b0;
  logic                  rst_async;
  logic                  pll_lock_i;
  logic                  ena_switch_i;
  logic [DATA_W-1:0]     data_i;
  logic [CTRL_IN_W-1:0]  data_ctrl_i;
  logic [DATA_W-1:0]     hash_i;
  logic [CTRL_OUT_W-1:0] hash_ctrl_i;
  logic                  err_i;
  logic [DATA_W-1:0]     core_data_o;
  logic [CTRL_IN_W-1:0]  core_ctrl_o;
  logic                  core_rst_n_o;
  logic                  core_ena_o;
  logic [DATA_W-1:0]     hash_o;
  logic [CTRL_OUT_W-1:0] hash_ctrl_o;
  logic [3:0]            status_o;

  pmod_bus_bridge #(
    .DATA_W(DATA_W), .CTRL_IN_W(CTRL_IN_W), .CTRL_OUT_W(CTRL_OUT_W),
    .SYNC_STAGES(SYNC_STAGES), .OUT_STAGES(OUT_STAGES), .LOCK_STABLE(LOCK_STABLE),
    .RST_HOLD(RST_HOLD), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HB_DIV(HB_DIV)
  ) dut (
    .clk(clk), .rst_async(rst_async), .pll_lock_i(pll_lock_i), .ena_switch_i(ena_switch_i),
    .data_i(data_i), .data_ctrl_i(data_ctrl_i), .hash_i(hash_i), .hash_ctrl_i(hash_ctrl_i),
    .err_i(err_i), .core_data_o(core_data_o), .core_ctrl_o(core_ctrl_o),
    .core_rst_n_o(core_rst_n_o), .core_ena_o(core_ena_o), .hash_o(hash_o),
    .hash_ctrl_o(hash_ctrl_o), .status_o(status_o)
  );

  always #5 clk = ~clk;

  // cyc == n between edge n and edge n+1
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Input history, index = cycle in which the value was driven
  bit                    rst_a   [MAXC];
  bit                    lock_a  [MAXC];
  bit                    ena_a   [MAXC];
  bit                    err_a   [MAXC];
  logic [DATA_W-1:0]     data_a  [MAXC];
  logic [CTRL_IN_W-1:0]  ctrl_a  [MAXC];
  logic [DATA_W-1:0]     hash_a  [MAXC];
  logic [CTRL_OUT_W-1:0] hctrl_a [MAXC];

  // Model history, index = cycle
  bit run_h    [MAXC];
  bit lk_h     [MAXC];
  bit sticky_h [MAXC];
  bit hb_h     [MAXC];
  bit ena_h    [MAXC];

  // Directed-scenario anchors (cycle numbers), set by the driver
  int t1_c0 = -100000;
  int t3_c  = -100000;
  int te_c  = -100000;
  int cd_c  = -100000;
  int c2_c  = -100000;
  int ea_c  = -100000;
  int eb_c  = -100000;
  int rr0_c = -100000;
  int rr_c  = -100000;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model + compare ----------------
  int valid_from = 0;
  int m_streak   = 0;
  int m_ediff    = 0;
  int m_hb       = 0;
  bit m_sticky   = 1'b0;
  bit m_ena      = 1'b0;

  function automatic bit lock_s_at(input int m);
    return (m - 2 >= valid_from && m >= 2) ? lock_a[m-2] : 1'b0;
  endfunction

  function automatic bit ena_s_at(input int m);
    return (m - 2 >= valid_from && m >= 2) ? ena_a[m-2] : 1'b0;
  endfunction

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, n, act, exp);
    end
  endtask

  always @(posedge clk) begin : compare
    int n;
    bit ls, es, er, was_run, in_rst;
    int ns;
    logic [DATA_W-1:0]     exp_d, exp_h;
    logic [CTRL_IN_W-1:0]  exp_c;
    logic [CTRL_OUT_W-1:0] exp_hc;
    logic [3:0]            exp_st;
    #2;
    n = cyc;
    if (n >= 1 && n < MAXC) begin
      in_rst = rst_a[n] || rst_a[n-1];
      if (in_rst) begin
        if (rst_a[n]) valid_from = n + 1;
        m_streak = 0; m_sticky = 1'b0; m_ena = 1'b0; m_ediff = 0; m_hb = 0;
      end else begin
        ls      = lock_s_at(n - 1);
        es      = ena_s_at(n - 1);
        er      = err_a[n-1];
        was_run = (m_streak >= RUN_AFTER);
        ns      = ls ? ((m_streak < 1000000) ? m_streak + 1 : m_streak) : 0;
        if (was_run && er) m_sticky = 1'b1;
        else if (ns == LOCK_STABLE) m_sticky = 1'b0;
        if (es == m_ena) m_ediff = 0;
        else begin
          m_ediff++;
          if (m_ediff == DEBOUNCE_CYCLES) begin
            m_ena   = es;
            m_ediff = 0;
          end
        end
        m_hb     = was_run ? m_hb + 1 : 0;
        m_streak = ns;
      end
      run_h[n]    = (m_streak >= RUN_AFTER);
      lk_h[n]     = lock_s_at(n);
      sticky_h[n] = m_sticky;
`ifdef BRIDGE_HEARTBEAT_EN
      hb_h[n]     = ((m_hb >> HB_DIV) & 1) != 0;
`else
      hb_h[n]     = 1'b0;
`endif
      ena_h[n]    = m_ena;

      exp_d  = '0; exp_c = '0; exp_h = '0; exp_hc = '0;
      if (run_h[n] && n - SYNC_STAGES >= valid_from) begin
        exp_d = data_a[n-SYNC_STAGES];
        exp_c = ctrl_a[n-SYNC_STAGES];
      end
      if (n - OUT_STAGES >= valid_from && run_h[n-OUT_STAGES]) begin
        exp_h  = hash_a[n-OUT_STAGES];
        exp_hc = hctrl_a[n-OUT_STAGES];
      end
      exp_st = in_rst ? 4'b0001 : {hb_h[n-1], sticky_h[n-1], lk_h[n-1], ~run_h[n-1]};

      chk("core_rst_n", n, 32'(core_rst_n_o), 32'(run_h[n]));
      chk("core_ena",   n, 32'(core_ena_o),   32'(ena_h[n]));
      chk("core_data",  n, 32'(core_data_o),  32'(exp_d));
      chk("core_ctrl",  n, 32'(core_ctrl_o),  32'(exp_c));
      chk("hash",       n, 32'(hash_o),       32'(exp_h));
      chk("hash_ctrl",  n, 32'(hash_ctrl_o),  32'(exp_hc));
      chk("status",     n, 32'(status_o),     32'(exp_st));

      // Hand-derived anchors
      if (n == t1_c0 + 25) chk("t1_rstn_low", n, 32'(core_rst_n_o), 32'd0);
      if (n == t1_c0 + 26) begin
        chk("t1_rstn_rise",  n, 32'(core_rst_n_o), 32'd1);
        chk("t1_model_run",  n, 32'(run_h[n]),     32'd1);
        chk("t1_status0_on", n, 32'(status_o[0]),  32'd1);
      end
      if (n == t1_c0 + 27) chk("t1_status0_off", n, 32'(status_o[0]), 32'd0);
      if (n == t3_c + 2) begin
        chk("t3_data",  n, 32'(core_data_o), 32'h0A5);
        chk("t3_ctrl",  n, 32'(core_ctrl_o), 32'h5);
        chk("t3_hash",  n, 32'(hash_o),      32'h03C);
        chk("t3_hctrl", n, 32'(hash_ctrl_o), 32'h2);
      end
      if (n == te_c + 1) chk("t5_err_not_yet", n, 32'(status_o[2]), 32'd0);
      if (n == te_c + 2) chk("t5_err_sticky",  n, 32'(status_o[2]), 32'd1);
      if (n == cd_c + 2) chk("t2_run_drop_still_high", n, 32'(core_rst_n_o), 32'd1);
      if (n == cd_c + 3) chk("t2_run_drop_low",        n, 32'(core_rst_n_o), 32'd0);
      if (n == c2_c + 18) chk("t5_err_before_hold", n, 32'(status_o[2]), 32'd1);
      if (n == c2_c + 19) chk("t5_err_cleared",     n, 32'(status_o[2]), 32'd0);
      if (n == c2_c + 25) chk("t2_reseq_low",  n, 32'(core_rst_n_o), 32'd0);
      if (n == c2_c + 26) begin
        chk("t2_reseq_rise", n, 32'(core_rst_n_o), 32'd1);
        chk("t5_wait_err_ignored", n, 32'(status_o[2]), 32'd0);
      end
      if (n == ea_c + 1002) chk("t4_short_pulse", n, 32'(core_ena_o), 32'd0);
      if (n == eb_c + 1001) chk("t4_ena_not_yet", n, 32'(core_ena_o), 32'd0);
      if (n == eb_c + 1002) chk("t4_ena_rise",    n, 32'(core_ena_o), 32'd1);
      if (n == rr0_c) begin
        chk("rst_mid_status", n, 32'(status_o),     32'h1);
        chk("rst_mid_rstn",   n, 32'(core_rst_n_o), 32'd0);
      end
      if (n == rr_c + 25) chk("rst_reseq_low",  n, 32'(core_rst_n_o), 32'd0);
      if (n == rr_c + 26) chk("rst_reseq_rise", n, 32'(core_rst_n_o), 32'd1);
    end
  end

  // ---------------- driver ----------------
  task automatic apply(input bit r, input bit l, input bit e, input bit er,
                       input logic [DATA_W-1:0] d, input logic [CTRL_IN_W-1:0] dc,
                       input logic [DATA_W-1:0] h, input logic [CTRL_OUT_W-1:0] hc);
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    rst_async = r; pll_lock_i = l; ena_switch_i = e; err_i = er;
    data_i = d; data_ctrl_i = dc; hash_i = h; hash_ctrl_i = hc;
    rst_a[cyc] = r; lock_a[cyc] = l; ena_a[cyc] = e; err_a[cyc] = er;
    data_a[cyc] = d; ctrl_a[cyc] = dc; hash_a[cyc] = h; hctrl_a[cyc] = hc;
  endtask

  task automatic tick(input bit r, input bit l, input bit e, input bit er);
    @(posedge clk); #1;
    apply(r, l, e, er, DATA_W'($urandom), CTRL_IN_W'($urandom),
          DATA_W'($urandom), CTRL_OUT_W'($urandom));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog cyc=%0d limit_reached=1", cyc);
    $fatal(1);
  end

  initial begin : driver
    bit ena_v;
    bit lock_v;
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
    // Waiting for lock; err activity here must be ignored
    repeat (5) tick(1'b0, 1'b0, 1'b0, 1'($urandom));

    // Lock rises and stays
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    t1_c0 = cyc;
    repeat (40) tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Directed data/hash in RUN
    @(posedge clk); #1;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 3'b101, 8'h3C, 2'b10);
    t3_c = cyc;
    repeat (5) tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Single err pulse in RUN, then random err
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    te_c = cyc;
    repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (50) tick(1'b0, 1'b1, 1'b0, ($urandom_range(0, 7) == 0));

    // Lock drop in RUN, then a one-cycle drop during re-qualification
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    cd_c = cyc;
    repeat (10) tick(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    c2_c = cyc;
    repeat (10) tick(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (30) tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Debounce: 999-cycle pulse, then a held level
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    ea_c = cyc;
    repeat (998) tick(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (1100) tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    eb_c = cyc;
    repeat (1100) tick(1'b0, 1'b1, 1'b1, 1'b0);
    // Bouncing switch with short runs, then settles low
    ena_v = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ena_v = ~ena_v;
      repeat ($urandom_range(1, 40)) tick(1'b0, 1'b1, ena_v, ($urandom_range(0, 15) == 0));
    end
    repeat (1100) tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of RUN
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    rr0_c = cyc;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    rr_c = cyc;
    repeat (40) tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Free random traffic
    ena_v = 1'b0;
    for (int k = 0; k < 2500; k++) begin
      lock_v = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 599) == 0) ena_v = ~ena_v;
      tick(($urandom_range(0, 1499) == 0), lock_v, ena_v, ($urandom_range(0, 15) == 0));
    end
    repeat (4) tick(1'b0, 1'b1, 1'b0, 1'b0);

    @(posedge clk); #4;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
